// File: rtl/reg_file_bank.sv
// rtl/reg_file_bank.sv - parametrised register file with byte-enabled write and bulk-clear sweep
//
// Two combinational read ports, one synchronous byte-enabled write port,
// optional hardwired-zero entry 0, and a clear engine that zeroes one entry
// per cycle while Busy is high (writes are refused for the whole sweep).
//
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding on both read ports.
//
// Ports:
//   clk       clock, all state updates on rising edge
//   rst_n     asynchronous active-low reset
//   A1, A2    read addresses            RD1, RD2  combinational read data
//   A3        write address             WD        write data
//   WBE       write byte enables        We        write request
//   Wr_rdy    write accepted iff We && Wr_rdy (high only when idle)
//   Clr       bulk-clear request        Busy      clear sweep in progress

module reg_file_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   A1,
    input  logic [ADDR_W-1:0]   A2,
    output logic [DATA_W-1:0]   RD1,
    output logic [DATA_W-1:0]   RD2,
    input  logic [ADDR_W-1:0]   A3,
    input  logic [DATA_W-1:0]   WD,
    input  logic [DATA_W/8-1:0] WBE,
    input  logic                We,
    output logic                Wr_rdy,
    input  logic                Clr,
    output logic                Busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic                r_wr_rdy;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_en;
    logic                w_wr_zero_hit;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;

    // Writes aimed at the hardwired-zero entry are silently dropped.
    assign w_wr_zero_hit = (ZERO_REG != 0) && (A3 == '0);
    assign w_wr_en       = We && r_wr_rdy && !w_wr_zero_hit;

    // Busy and Wr_rdy are kept as registered copies of the state so the
    // outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_wr_rdy <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A write and a clear request on the same edge both take
                    // effect; the sweep will zero the written entry later.
                    if (w_wr_en) begin
                        for (int b = 0; b < NB; b++) begin
                            if (WBE[b]) begin
                                r_mem[A3][8*b +: 8] <= WD[8*b +: 8];
                            end
                        end
                    end
                    if (Clr) begin
                        r_state  <= S_CLEAR;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_wr_rdy <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_mem[r_cnt] <= '0;
                    // Counter wraps naturally back to 0 on the last entry.
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_wr_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_wr_rdy <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_rd1 = r_mem[A1];
`ifdef REGFILE_BYPASS_EN
        if (We && r_wr_rdy && (A1 == A3)) begin
            for (int b = 0; b < NB; b++) begin
                if (WBE[b]) begin
                    w_rd1[8*b +: 8] = WD[8*b +: 8];
                end
            end
        end
`endif
        // Zero override last, so forwarding can never leak into entry 0.
        if ((ZERO_REG != 0) && (A1 == '0)) begin
            w_rd1 = '0;
        end
    end

    always_comb begin
        w_rd2 = r_mem[A2];
`ifdef REGFILE_BYPASS_EN
        if (We && r_wr_rdy && (A2 == A3)) begin
            for (int b = 0; b < NB; b++) begin
                if (WBE[b]) begin
                    w_rd2[8*b +: 8] = WD[8*b +: 8];
                end
            end
        end
`endif
        if ((ZERO_REG != 0) && (A2 == '0)) begin
            w_rd2 = '0;
        end
    end

    assign RD1    = w_rd1;
    assign RD2    = w_rd2;
    assign Busy   = r_busy;
    assign Wr_rdy = r_wr_rdy;

endmodule
